// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared encodings for the acc_core accumulator
//
// Holds the opcode encodings driven by the instruction decoder, the
// two-state control FSM encoding and the bit positions of the status
// flags inside the flag register.

package acc_pkg;

  localparam int OPC_BITS = 24;

  localparam logic [OPC_BITS-1:0] OP_LDA = 24'h000001;
  localparam logic [OPC_BITS-1:0] OP_CLR = 24'h000002;
  localparam logic [OPC_BITS-1:0] OP_INC = 24'h000003;
  localparam logic [OPC_BITS-1:0] OP_DEC = 24'h000004;
  localparam logic [OPC_BITS-1:0] OP_ADD = 24'h000005;
  localparam logic [OPC_BITS-1:0] OP_SUB = 24'h000006;
  localparam logic [OPC_BITS-1:0] OP_AND = 24'h000007;
  localparam logic [OPC_BITS-1:0] OP_OR  = 24'h000008;
  localparam logic [OPC_BITS-1:0] OP_XOR = 24'h000009;
  localparam logic [OPC_BITS-1:0] OP_SHL = 24'h00000A;
  localparam logic [OPC_BITS-1:0] OP_SHR = 24'h00000B;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - combinational single-step accumulator ALU
//
// Ports:
//   op     in  OPCODE_W  operation code (acc_pkg encodings)
//   acc    in  W         current accumulator
//   din    in  W         operand
//   result out W         new accumulator value
//   carry  out 1         carry / borrow / bit shifted out
//   legal  out 1         op is a known encoding
// SHL/SHR perform a single one-bit step; the caller sequences multi-bit shifts.

module acc_alu
  import acc_pkg::*;
#(
  parameter int W        = 8,
  parameter int OPCODE_W = 24
) (
  input  logic [OPCODE_W-1:0] op,
  input  logic [W-1:0]        acc,
  input  logic [W-1:0]        din,
  output logic [W-1:0]        result,
  output logic                carry,
  output logic                legal
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_comb begin
    result = acc;
    carry  = 1'b0;
    legal  = 1'b1;
    case (op)
      OPCODE_W'(OP_LDA): result = din;
      OPCODE_W'(OP_CLR): result = '0;
      OPCODE_W'(OP_INC): {carry, result} = {1'b0, acc} + {1'b0, ONE};
      OPCODE_W'(OP_DEC): begin
        result = acc - ONE;
        carry  = (acc == '0);
      end
      OPCODE_W'(OP_ADD): {carry, result} = {1'b0, acc} + {1'b0, din};
      OPCODE_W'(OP_SUB): begin
        result = acc - din;
        carry  = (din > acc);
      end
      OPCODE_W'(OP_AND): result = acc & din;
      OPCODE_W'(OP_OR):  result = acc | din;
      OPCODE_W'(OP_XOR): result = acc ^ din;
      OPCODE_W'(OP_SHL): begin
        result = {acc[W-2:0], 1'b0};
        carry  = acc[W-1];
      end
      OPCODE_W'(OP_SHR): begin
        result = {1'b0, acc[W-1:1]};
        carry  = acc[0];
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/acc_core.sv
// rtl/acc_core.sv - accumulator core with flags and serial shifter
//
// Ports:
//   clk          in  1         system clock, rising edge
//   acc_rst      in  1         asynchronous active-high reset
//   acc_en       in  1         enable; low freezes all state
//   opcode       in  OPCODE_W  operation code
//   op_rdy       in  1         opcode/operand valid
//   acc_data_in  in  W         operand, or shift amount in [SH_W-1:0]
//   op_ack       out 1         operation accepted this cycle
//   busy         out 1         serial shift in progress
//   done         out 1         one-cycle pulse: result/flags updated
//   op_err       out 1         one-cycle pulse with done: illegal opcode
//   acc_out      out W         accumulator
//   flag_z/c/n   out 1         zero, carry/borrow, MSB flags

module acc_core
  import acc_pkg::*;
#(
  parameter int W        = 8,
  parameter int OPCODE_W = 24,
  parameter int SH_W     = $clog2(W) + 1
) (
  input  logic                clk,
  input  logic                acc_rst,
  input  logic                acc_en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                op_rdy,
  input  logic [W-1:0]        acc_data_in,
  output logic                op_ack,
  output logic                busy,
  output logic                done,
  output logic                op_err,
  output logic [W-1:0]        acc_out,
  output logic                flag_z,
  output logic                flag_c,
  output logic                flag_n
);

  localparam logic [SH_W-1:0] W_SH   = SH_W'(W);
  localparam logic [SH_W-1:0] ONE_SH = SH_W'(1);

  state_t              state, state_nxt;
  logic [SH_W-1:0]     count;
  logic [OPCODE_W-1:0] shift_op;
  logic [W-1:0]        acc;
  logic [2:0]          flags;
  logic                done_q, err_q;

  logic                accept;
  logic                is_shift;
  logic [SH_W-1:0]     shamt, shamt_clamped;
  logic [OPCODE_W-1:0] alu_op;
  logic [W-1:0]        alu_result;
  logic                alu_carry, alu_legal;

  assign accept        = acc_en && op_rdy && (state == ST_IDLE);
  assign is_shift      = (opcode == OPCODE_W'(OP_SHL)) || (opcode == OPCODE_W'(OP_SHR));
  assign shamt         = acc_data_in[SH_W-1:0];
  assign shamt_clamped = (shamt > W_SH) ? W_SH : shamt;

  // While shifting, the latched shift opcode drives the ALU so the decoder
  // may present the next request on opcode without disturbing the shift.
  assign alu_op = (state == ST_SHIFT) ? shift_op : opcode;

  acc_alu #(
    .W        (W),
    .OPCODE_W (OPCODE_W)
  ) u_alu (
    .op     (alu_op),
    .acc    (acc),
    .din    (acc_data_in),
    .result (alu_result),
    .carry  (alu_carry),
    .legal  (alu_legal)
  );

  always_ff @(posedge clk or posedge acc_rst) begin
    if (acc_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept && is_shift && (shamt != '0)) state_nxt = ST_SHIFT;
      ST_SHIFT: if (acc_en && (count == ONE_SH))         state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state == ST_SHIFT);
    op_ack = accept;
  end

  always_ff @(posedge clk or posedge acc_rst) begin
    if (acc_rst) begin
      acc      <= '0;
      flags    <= '0;
      count    <= '0;
      shift_op <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept) begin
        if (is_shift && (shamt != '0)) begin
          count    <= shamt_clamped;
          shift_op <= opcode;
        end else if (is_shift) begin
          // zero-length shift: value untouched, only flags refresh
          flags[FLAG_C] <= 1'b0;
          flags[FLAG_Z] <= (acc == '0);
          flags[FLAG_N] <= acc[W-1];
          done_q        <= 1'b1;
        end else if (alu_legal) begin
          acc           <= alu_result;
          flags[FLAG_C] <= alu_carry;
          flags[FLAG_Z] <= (alu_result == '0);
          flags[FLAG_N] <= alu_result[W-1];
          done_q        <= 1'b1;
        end else begin
          done_q <= 1'b1;
          err_q  <= 1'b1;
        end
      end else if ((state == ST_SHIFT) && acc_en) begin
        acc   <= alu_result;
        count <= count - ONE_SH;
        // flags only reflect the final step, so c is the last bit shifted out
        if (count == ONE_SH) begin
          flags[FLAG_C] <= alu_carry;
          flags[FLAG_Z] <= (alu_result == '0);
          flags[FLAG_N] <= alu_result[W-1];
          done_q        <= 1'b1;
        end
      end
    end
  end

  assign done    = done_q;
  assign op_err  = err_q;
  assign acc_out = acc;
  assign flag_z  = flags[FLAG_Z];
  assign flag_c  = flags[FLAG_C];
  assign flag_n  = flags[FLAG_N];

endmodule

// File: tb/tb_acc_core.sv
// tb/tb_acc_core.sv - self-checking bench for acc_core

module tb_acc_core;
  import acc_pkg::*;

  logic        clk = 1'b0;
  logic        acc_rst;
  logic        acc_en;
  logic [23:0] opcode;
  logic        op_rdy;
  logic [7:0]  acc_data_in;
  logic        op_ack, busy, done, op_err;
  logic [7:0]  acc_out;
  logic        flag_z, flag_c, flag_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  acc_core #(.W(8), .OPCODE_W(24)) dut (
    .clk         (clk),
    .acc_rst     (acc_rst),
    .acc_en      (acc_en),
    .opcode      (opcode),
    .op_rdy      (op_rdy),
    .acc_data_in (acc_data_in),
    .op_ack      (op_ack),
    .busy        (busy),
    .done        (done),
    .op_err      (op_err),
    .acc_out     (acc_out),
    .flag_z      (flag_z),
    .flag_c      (flag_c),
    .flag_n      (flag_n)
  );

  typedef struct {
    logic [23:0] op;
    logic [7:0]  din;
    logic [7:0]  acc;
    logic        z;
    logic        c;
    logic        n;
    logic        err;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [7:0] a, input logic z,
                           input logic c, input logic n);
    chk({name, "_acc"}, 32'(acc_out), 32'(a));
    chk({name, "_flags"}, {29'd0, flag_z, flag_c, flag_n}, {29'd0, z, c, n});
  endtask

  // Presents one request, checks it is acked, and returns 1ns after the accept edge.
  task automatic issue(input string name, input logic [23:0] op, input logic [7:0] d);
    @(negedge clk);
    opcode = op; acc_data_in = d; op_rdy = 1'b1;
    #1 chk({name, "_ack"}, 32'(op_ack), 32'd1);
    @(posedge clk);
    #1 op_rdy = 1'b0;
  endtask

  // Counts busy cycles of a shift already accepted; returns with busy low.
  task automatic run_shift(input string name, input int exp_busy, input logic [7:0] a,
                           input logic z, input logic c, input logic n);
    int cyc;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      @(posedge clk);
      #1;
    end
    chk({name, "_busy_cycles"}, 32'(cyc), 32'(exp_busy));
    chk({name, "_done"}, 32'(done), 32'd1);
    chk_state(name, a, z, c, n);
    @(posedge clk);
    #1 chk({name, "_done_drop"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    acc_rst = 1'b1; acc_en = 1'b1; opcode = '0; op_rdy = 1'b0; acc_data_in = '0;

    vt[0]  = '{OP_LDA, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{OP_INC, 8'h00, 8'hA6, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{OP_INC, 8'h00, 8'hA7, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{OP_LDA, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{OP_INC, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{OP_DEC, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[6]  = '{OP_LDA, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{OP_SUB, 8'h20, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0};
    vt[8]  = '{OP_ADD, 8'h20, 8'h10, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{OP_AND, 8'h30, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{OP_OR,  8'h81, 8'h91, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[11] = '{OP_XOR, 8'h91, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[12] = '{24'hFFFFFF, 8'h33, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[13] = '{OP_LDA, 8'h05, 8'h05, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[14] = '{OP_SUB, 8'h05, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[15] = '{OP_LDA, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[16] = '{OP_SHL, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[17] = '{OP_CLR, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_state("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    acc_rst = 1'b0;

    foreach (vt[i]) begin
      issue($sformatf("vec%0d", i), vt[i].op, vt[i].din);
      chk($sformatf("vec%0d_done", i), 32'(done), 32'd1);
      chk($sformatf("vec%0d_err", i), 32'(op_err), 32'(vt[i].err));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      chk_state($sformatf("vec%0d", i), vt[i].acc, vt[i].z, vt[i].c, vt[i].n);
    end
    @(posedge clk);
    #1 chk("done_single_pulse", 32'(done), 32'd0);
    chk("err_single_pulse", 32'(op_err), 32'd0);

    issue("lda81", OP_LDA, 8'h81);
    issue("shl3", OP_SHL, 8'd3);
    chk("shl3_busy_start", 32'(busy), 32'd1);
    run_shift("shl3", 3, 8'h08, 1'b0, 1'b0, 1'b0);

    issue("shr9", OP_SHR, 8'd9);
    run_shift("shr9", 8, 8'h00, 1'b1, 1'b0, 1'b0);

    issue("lda06", OP_LDA, 8'h06);
    issue("shr2", OP_SHR, 8'd2);
    run_shift("shr2", 2, 8'h01, 1'b0, 1'b1, 1'b0);

    // shift with two stalled cycles and a competing request held while busy
    issue("lda0b", OP_LDA, 8'h0B);
    issue("shl5", OP_SHL, 8'd5);
    cyc = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      @(negedge clk);
      acc_en = !(i == 1 || i == 2);
      opcode = OP_LDA; acc_data_in = 8'h55; op_rdy = 1'b1;
      #1 chk($sformatf("no_ack_busy%0d", i), 32'(op_ack), 32'd0);
      @(posedge clk);
      #1 if (busy) cyc++;
    end
    chk("stall_busy_cycles", 32'(cyc), 32'd7);
    chk("stall_done", 32'(done), 32'd1);
    chk_state("stall", 8'h60, 1'b0, 1'b1, 1'b0);
    chk("ack_with_done", 32'(op_ack), 32'd1);
    @(posedge clk);
    #1 op_rdy = 1'b0;
    chk("held_req_done", 32'(done), 32'd1);
    chk_state("held_req", 8'h55, 1'b0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a shift
    issue("ldaf0", OP_LDA, 8'hF0);
    issue("shl4", OP_SHL, 8'd4);
    @(posedge clk);
    #3 acc_rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk_state("arst", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    acc_rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_idle", 32'(busy), 32'd0);
    chk_state("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
